regfile_sb: RTL

- Integer register file with a pending-write scoreboard. It answers the decode stage's register read requests (rs1/rs2 enable and address) with operand data and a per-operand busy flag.
- It accepts one writeback per cycle and one issue-time destination reservation per cycle.
- It sits between the decode stage (read side), issue control (reservations) and the writeback stage (write side).
- x0 is hardwired to zero and is never busy.

---
 rtl/regfile_sb_if.sv | 42 ++++
 rtl/regfile_sb.sv | 137 +++++++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Bundle of the register file's read, writeback, issue-reservation and
// scoreboard-status signals.
//   master : the pipeline side (decode, issue control, writeback)
//   slave  : the register file itself
interface regfile_sb_if #(
  parameter int XLEN = 64
);
  // decode read port 1
  logic            rs1_r_ena;
  logic [4:0]      rs1_r_addr;
  logic [XLEN-1:0] rs1_data;
  logic            rs1_busy;
  // decode read port 2
  logic            rs2_r_ena;
  logic [4:0]      rs2_r_addr;
  logic [XLEN-1:0] rs2_data;
  logic            rs2_busy;
  // writeback port
  logic            rd_w_ena;
  logic [4:0]      rd_w_addr;
  logic [XLEN-1:0] rd_w_data;
  // issue-time reservation and flush
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            flush;
  // number of registers with an outstanding writer
  logic [5:0]      busy_cnt;

  modport master (
    output rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr,
    output rd_w_ena, rd_w_addr, rd_w_data,
    output iss_valid, iss_rd, flush,
    input  rs1_data, rs1_busy, rs2_data, rs2_busy, busy_cnt
  );

  modport slave (
    input  rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr,
    input  rd_w_ena, rd_w_addr, rd_w_data,
    input  iss_valid, iss_rd, flush,
    output rs1_data, rs1_busy, rs2_data, rs2_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with a pending-write scoreboard.
// Two combinational read ports, one writeback port, one destination
// reservation per cycle and a flush that drops every reservation.
// x0 reads as zero and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a writeback in
// the current cycle is forwarded to a matching read port and that port's
// busy flag is suppressed.
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  // Population count of the busy vector (bit 0 is always clear, so <= 31).
  function automatic logic [5:0] popcount(input logic [NREG-1:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  logic [XLEN-1:0] regs_r [NREG];
  logic [NREG-1:0] busy_r;
  logic [5:0]      cnt_r;

  logic            w_hit_s;
  logic            iss_hit_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] busy_nxt_s;

  logic [XLEN-1:0] rs1_data_s;
  logic            rs1_busy_s;
  logic [XLEN-1:0] rs2_data_s;
  logic            rs2_busy_s;

  assign w_hit_s   = bus.rd_w_ena  & (bus.rd_w_addr != 5'd0);
  assign iss_hit_s = bus.iss_valid & (bus.iss_rd    != 5'd0);

  // Next scoreboard state: flush clears all, otherwise a reservation beats a
  // same-register writeback because the newer producer is still outstanding.
  always_comb begin
    set_mask_s = {NREG{1'b0}};
    clr_mask_s = {NREG{1'b0}};
    busy_nxt_s = busy_r;
    if (iss_hit_s) begin
      set_mask_s = {{(NREG-1){1'b0}}, 1'b1} << bus.iss_rd;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (w_hit_s) begin
      clr_mask_s = {{(NREG-1){1'b0}}, 1'b1} << bus.rd_w_addr;
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
    if (bus.flush) begin
      busy_nxt_s = {NREG{1'b0}};
    end else begin
      busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Register array: writeback commits even during a flush; x0 never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (w_hit_s) begin
      regs_r[bus.rd_w_addr] <= bus.rd_w_data;
    end
  end

  // Scoreboard bits and their registered population count, updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NREG{1'b0}};
      cnt_r  <= 6'd0;
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= popcount(busy_nxt_s);
    end
  end

  // Read port 1: zero for disabled/x0/reset, optional same-cycle forwarding.
  always_comb begin
    rs1_data_s = {XLEN{1'b0}};
    rs1_busy_s = 1'b0;
    if (rst || !bus.rs1_r_ena || (bus.rs1_r_addr == 5'd0)) begin
      rs1_data_s = {XLEN{1'b0}};
      rs1_busy_s = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (w_hit_s && (bus.rd_w_addr == bus.rs1_r_addr)) begin
      rs1_data_s = bus.rd_w_data;
      rs1_busy_s = 1'b0;
    end
`endif
    else begin
      rs1_data_s = regs_r[bus.rs1_r_addr];
      rs1_busy_s = busy_r[bus.rs1_r_addr];
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    rs2_data_s = {XLEN{1'b0}};
    rs2_busy_s = 1'b0;
    if (rst || !bus.rs2_r_ena || (bus.rs2_r_addr == 5'd0)) begin
      rs2_data_s = {XLEN{1'b0}};
      rs2_busy_s = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (w_hit_s && (bus.rd_w_addr == bus.rs2_r_addr)) begin
      rs2_data_s = bus.rd_w_data;
      rs2_busy_s = 1'b0;
    end
`endif
    else begin
      rs2_data_s = regs_r[bus.rs2_r_addr];
      rs2_busy_s = busy_r[bus.rs2_r_addr];
    end
  end

  assign bus.rs1_data = rs1_data_s;
  assign bus.rs1_busy = rs1_busy_s;
  assign bus.rs2_data = rs2_data_s;
  assign bus.rs2_busy = rs2_busy_s;
  assign bus.busy_cnt = cnt_r;

endmodule
